alu_issue_ctrl: RTL and testbench

- Initiator side of the CPU ALU interface.
- Accepts 8-bit register-to-register instructions over a valid/ready handshake and reads operands from an internal 4x8 register file.
- Drives the ALU's a/b/op/alu_en inputs for the ALU's registered latency, then samples the result and flags and writes them back.
- Sits between instruction decode and the ALU in the 8-bit datapath.

---
 rtl/alu_issue_ctrl_if.sv | 25 ++
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/result bus between the issue controller
// (master) and the decode/ALU side (slave).
interface alu_issue_ctrl_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_en;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_zero;
  logic       alu_ovf;

  modport master (
    input  instr_valid, instr, alu_res, alu_c, alu_zero, alu_ovf,
    output instr_ready, alu_a, alu_b, alu_op, alu_en
  );

  modport slave (
    output instr_valid, instr, alu_res, alu_c, alu_zero, alu_ovf,
    input  instr_ready, alu_a, alu_b, alu_op, alu_en
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: 4x8 register file, IDLE/ISSUE/WB sequencing of a multi-cycle ALU.
// Optional retire counter port enabled by defining ALU_ISSUE_RETIRE_CNT_EN.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus,
  input  logic              ld_en,
  input  logic [1:0]        ld_sel,
  input  logic [7:0]        ld_data,
  input  logic [1:0]        rd_sel,
  output logic [7:0]        rd_data,
  output logic [2:0]        flags,
  output logic              busy,
  output logic              done
`ifdef ALU_ISSUE_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  if (ALU_LAT < 1 || ALU_LAT > 7 || CNT_W < 1) begin : g_param_chk
    $error("alu_issue_ctrl: ALU_LAT must be 1..7 and CNT_W >= 1");
  end

  localparam logic [2:0] LAST = 3'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      rd_q, rd_d;
  logic            cmp_q, cmp_d;
  logic [3:0][7:0] regs_q;
  logic [2:0]      flags_q;
  logic            unary;

  // NOT, INC and DEC take no second operand
  assign unary = (bus.instr[7:5] == 3'b011) || (bus.instr[7:5] == 3'b110) ||
                 (bus.instr[7:5] == 3'b111);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    cmp_d   = cmp_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid && bus.instr_ready) begin
          a_d     = regs_q[bus.instr[4:3]];
          b_d     = unary ? 8'h00 : regs_q[bus.instr[2:1]];
          op_d    = bus.instr[7:5];
          rd_d    = bus.instr[4:3];
          cmp_d   = bus.instr[0];
          cnt_d   = 3'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      cmp_q   <= cmp_d;
    end
  end

  // Loads are honoured only in IDLE; writeback owns the file during WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q  <= '0;
      flags_q <= '0;
    end else if (state_q == IDLE && ld_en) begin
      regs_q[ld_sel] <= ld_data;
    end else if (state_q == WB) begin
      flags_q <= {bus.alu_c, bus.alu_zero, bus.alu_ovf};
      if (!cmp_q) regs_q[rd_q] <= bus.alu_res;
    end
  end

  assign bus.instr_ready = (state_q == IDLE) && !ld_en && !rst;
  assign bus.alu_en      = (state_q == ISSUE);
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == WB);
  assign flags           = flags_q;
  assign rd_data         = regs_q[rd_sel];

`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 retire_cnt_q <= '0;
    else if (state_q == WB)  retire_cnt_q <= retire_cnt_q + CNT_W'(1);
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a latency-accurate ALU model on the slave side.
module tb_alu_issue_ctrl;
  localparam int ALU_LAT = 2;
  localparam int CNT_W   = 2;

  localparam logic [2:0] OP_XOR = 3'd2, OP_ADD = 3'd4, OP_SUB = 3'd5, OP_INC = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_en = 1'b0;
  logic [1:0] ld_sel = '0;
  logic [7:0] ld_data = '0;
  logic [1:0] rd_sel = '0;
  logic [7:0] rd_data;
  logic [2:0] flags;
  logic       busy, done;
`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .flags(flags), .busy(busy), .done(done)
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- ALU reference / slave model ----------------
  function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s; logic [7:0] r; logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd5: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd6: begin s = {1'b0, a} + 9'd1; r = s[7:0]; c = s[8]; v = (a == 8'h7F); end
      default: begin s = {1'b0, a} - 9'd1; r = s[7:0]; c = s[8]; v = (a == 8'h80); end
    endcase
    return {c, (r == 8'h00), v, r};
  endfunction

  function automatic bit is_unary(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
  endfunction

  // Result is only valid after exactly ALU_LAT consecutive enable cycles; junk otherwise
  int         en_run = 0;
  logic [7:0] la = '0, lb = '0;
  logic [2:0] lop = '0;
  logic [10:0] alu_out;

  always @(posedge clk or posedge rst) begin
    if (rst) en_run <= 0;
    else if (bus.alu_en) begin
      en_run <= en_run + 1; la <= bus.alu_a; lb <= bus.alu_b; lop <= bus.alu_op;
    end else en_run <= 0;
  end

  assign alu_out = alu_fn(lop, la, lb);
  always_comb begin
    if (en_run == ALU_LAT) {bus.alu_c, bus.alu_zero, bus.alu_ovf, bus.alu_res} = alu_out;
    else                   {bus.alu_c, bus.alu_zero, bus.alu_ovf, bus.alu_res} = 11'h5A5;
  end

  // ---------------- bus monitor (negedge) ----------------
  int         en_total = 0, done_total = 0, unstable_total = 0;
  logic       prev_en = 1'b0;
  logic [7:0] last_a = '0, last_b = '0;
  logic [2:0] last_op = '0;

  always @(negedge clk) begin
    if (bus.alu_en) begin
      en_total <= en_total + 1;
      if (prev_en && {bus.alu_a, bus.alu_b, bus.alu_op} != {last_a, last_b, last_op})
        unstable_total <= unstable_total + 1;
      last_a <= bus.alu_a; last_b <= bus.alu_b; last_op <= bus.alu_op;
    end
    prev_en <= bus.alu_en;
    if (done) done_total <= done_total + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0] rd; logic cmp; logic [2:0] op;
    logic [7:0] a, b, old, res; logic [2:0] flags;
  } sb_t;

  sb_t        exp_q[$];
  logic [7:0] m_regs[4];
  int         en0 = 0, d0 = 0, u0 = 0;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic cmp);
    sb_t e; logic [10:0] r;
    e.op = op; e.rd = rd; e.cmp = cmp;
    e.a = m_regs[rd]; e.b = is_unary(op) ? 8'h00 : m_regs[rs]; e.old = m_regs[rd];
    r = alu_fn(op, e.a, e.b); e.flags = r[10:8]; e.res = r[7:0];
    exp_q.push_back(e);
    en0 = en_total; d0 = done_total; u0 = unstable_total;
  endtask

  task automatic ld(input logic [1:0] sel, input logic [7:0] d);
    tick(); ld_en = 1'b1; ld_sel = sel; ld_data = d; #1;
    n_chk++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL ld_blocks_ready: got %b expected 0", bus.instr_ready); end
    tick(); ld_en = 1'b0; m_regs[sel] = d;
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic cmp, input bit hold);
    bit ok; ok = 0;
    tick();
    push_exp(op, rd, rs, cmp);
    bus.instr = {op, rd, rs, cmp}; bus.instr_valid = 1'b1; #1;
    for (int k = 0; k < 20; k++) begin
      if (bus.instr_ready === 1'b1) begin ok = 1; break; end
      tick();
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL %s accept: instr_ready never rose within 20 cycles", name); end
    @(posedge clk); #1;
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  task automatic retire(input string name);
    sb_t e; int j; int early; bit got;
    got = 0; early = 0; j = 0;
    n_chk++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL %s: scoreboard empty at retire", name); return; end
    rd_sel = exp_q[0].rd;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done === 1'b1) begin got = 1; j = k; break; end
      if (bus.instr_ready !== 1'b0) early++;
    end
    e = exp_q.pop_front();
    n_chk++; if (!got) begin n_fail++; $display("FAIL %s done: no done pulse within 20 cycles", name); return; end
    n_chk++; if (j !== ALU_LAT + 1) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, j, ALU_LAT + 1); end
    n_chk++; if (en_total - en0 !== ALU_LAT) begin n_fail++; $display("FAIL %s en_cycles: got %0d expected %0d", name, en_total - en0, ALU_LAT); end
    n_chk++; if ({last_a, last_b, last_op} !== {e.a, e.b, e.op}) begin n_fail++;
      $display("FAIL %s operands: got a=%h b=%h op=%0d expected a=%h b=%h op=%0d", name, last_a, last_b, last_op, e.a, e.b, e.op); end
    n_chk++; if (unstable_total - u0 !== 0) begin n_fail++; $display("FAIL %s stable: %0d operand changes during alu_en, expected 0", name, unstable_total - u0); end
    n_chk++; if (early !== 0) begin n_fail++; $display("FAIL %s ready_busy: ready seen %0d busy cycles, expected 0", name, early); end
    n_chk++; if (rd_data !== e.old) begin n_fail++; $display("FAIL %s rd_old_in_wb: got %h expected %h", name, rd_data, e.old); end
    tick();
    n_chk++; if (flags !== e.flags) begin n_fail++; $display("FAIL %s flags: got %b expected %b", name, flags, e.flags); end
    n_chk++; if (rd_data !== (e.cmp ? e.old : e.res)) begin n_fail++;
      $display("FAIL %s writeback: got %h expected %h", name, rd_data, e.cmp ? e.old : e.res); end
    n_chk++; if ({done, busy, bus.instr_ready} !== 3'b001) begin n_fail++;
      $display("FAIL %s post_wb: got done/busy/ready=%b expected 001", name, {done, busy, bus.instr_ready}); end
    n_chk++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_total - d0); end
    if (!e.cmp) m_regs[e.rd] = e.res;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_chk++; if ({bus.instr_ready, busy, bus.alu_en, done, flags} !== 7'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got ready/busy/en/done/flags=%b expected 0", {bus.instr_ready, busy, bus.alu_en, done, flags}); end
    n_chk++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 19'b0) begin n_fail++;
      $display("FAIL reset_alu_bus: got %h expected 0", {bus.alu_a, bus.alu_b, bus.alu_op}); end
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    n_chk++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL reset_retire_cnt: got %0d expected 0", retire_cnt); end
`endif
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    rst = 1'b0;
    tick();
    n_chk++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", bus.instr_ready); end
  endtask

  task automatic test_add();
    ld(2'd0, 8'h05); ld(2'd1, 8'h03);
    issue("add", OP_ADD, 2'd0, 2'd1, 1'b0, 1'b0);
    retire("add");
    rd_sel = 2'd0; #1;
    n_chk++; if ({rd_data, flags} !== {8'h08, 3'b000}) begin n_fail++; $display("FAIL add_const: got %h/%b expected 08/000", rd_data, flags); end
  endtask

  task automatic test_carry_zero();
    ld(2'd2, 8'hFF); ld(2'd3, 8'h01);
    issue("carry", OP_ADD, 2'd2, 2'd3, 1'b0, 1'b0);
    retire("carry");
    rd_sel = 2'd2; #1;
    n_chk++; if ({rd_data, flags} !== {8'h00, 3'b110}) begin n_fail++; $display("FAIL carry_const: got %h/%b expected 00/110", rd_data, flags); end
  endtask

  task automatic test_reset_mid_issue();
    int dsnap;
    ld(2'd0, 8'h55);
    issue("rst_mid", OP_ADD, 2'd0, 2'd0, 1'b0, 1'b0);
    dsnap = done_total;
    tick();
    n_chk++; if ({bus.alu_en, bus.alu_a} !== {1'b1, 8'h55}) begin n_fail++;
      $display("FAIL rst_mid_issuing: got en=%b a=%h expected en=1 a=55", bus.alu_en, bus.alu_a); end
    rst = 1'b1; #1;
    n_chk++; if ({bus.alu_en, busy, done, flags, bus.instr_ready} !== 7'b0) begin n_fail++;
      $display("FAIL rst_mid_ctrl: got en/busy/done/flags/ready=%b expected 0", {bus.alu_en, busy, done, flags, bus.instr_ready}); end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_reg%0d: got %h expected 00", i, rd_data); end
      m_regs[i] = 8'h00;
    end
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_chk++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", bus.instr_ready); end
    repeat (4) tick();
    n_chk++; if (done_total !== dsnap) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_total - dsnap); end
  endtask

  task automatic test_cmp();
    ld(2'd0, 8'h10); ld(2'd1, 8'h10);
    issue("cmp", OP_SUB, 2'd0, 2'd1, 1'b1, 1'b0);
    retire("cmp");
    rd_sel = 2'd0; #1;
    n_chk++; if ({rd_data, flags} !== {8'h10, 3'b010}) begin n_fail++; $display("FAIL cmp_const: got %h/%b expected 10/010", rd_data, flags); end
  endtask

  task automatic test_unary();
    ld(2'd1, 8'h7F); ld(2'd2, 8'h44);
    issue("inc", OP_INC, 2'd1, 2'd2, 1'b0, 1'b0);
    retire("inc");
    rd_sel = 2'd1; #1;
    n_chk++; if ({rd_data, flags, last_b} !== {8'h80, 3'b001, 8'h00}) begin n_fail++;
      $display("FAIL inc_const: got r1=%h flags=%b b=%h expected 80/001/00", rd_data, flags, last_b); end
  endtask

  // Second instruction held valid through the first one; a load is attempted mid-ISSUE
  task automatic test_back_to_back();
    ld(2'd0, 8'h01); ld(2'd1, 8'h02); ld(2'd3, 8'h33);
    issue("b2b_a", OP_ADD, 2'd0, 2'd1, 1'b0, 1'b1);
    bus.instr = {OP_ADD, 2'd0, 2'd0, 1'b0};
    ld_en = 1'b1; ld_sel = 2'd3; ld_data = 8'hEE;
    fork
      retire("b2b_a");
      begin @(negedge clk); #2; ld_en = 1'b0; end
    join
    push_exp(OP_ADD, 2'd0, 2'd0, 1'b0);
    n_chk++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got %b expected 1", bus.instr_ready); end
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_first_ready: got busy=%b expected 1", busy); end
    bus.instr_valid = 1'b0;
    retire("b2b_b");
    rd_sel = 2'd0; #1;
    n_chk++; if (rd_data !== 8'h06) begin n_fail++; $display("FAIL b2b_result: got %h expected 06", rd_data); end
    rd_sel = 2'd3; #1;
    n_chk++; if (rd_data !== 8'h33) begin n_fail++; $display("FAIL ld_in_issue_ignored: got %h expected 33", rd_data); end
  endtask

`ifdef ALU_ISSUE_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    logic [CNT_W-1:0] tab [5];
    tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tick(); rst = 1'b1; #1;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    exp_q.delete();
    tick(); rst = 1'b0;
    ld(2'd0, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      issue("rcnt", OP_XOR, 2'(i), 2'(i + 1), 1'(i), 1'b0);
      retire("rcnt");
      n_chk++; if (retire_cnt !== tab[i]) begin n_fail++; $display("FAIL retire_cnt[%0d]: got %0d expected %0d", i, retire_cnt, tab[i]); end
    end
  endtask
`endif

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    test_reset();
    test_add();
    test_carry_zero();
    test_reset_mid_issue();
    test_cmp();
    test_unary();
    test_back_to_back();
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
